// File: rtl/unsigned_seq_mult_rs_pkg.sv
// Shared constants and types for the right-shift sequential multiplier.
package unsigned_seq_mult_rs_pkg;

  localparam int USM_WIDTH  = 6;
  localparam int USM_PROD_W = 2 * USM_WIDTH;

  // Step counter must be able to hold 0..WIDTH.
  function automatic int usm_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } usm_state_e;

endpackage

// File: rtl/unsigned_seq_mult_rs_if.sv
// Operand/result bundle for the sequential multiplier.
interface unsigned_seq_mult_rs_if #(
  parameter int WIDTH = unsigned_seq_mult_rs_pkg::USM_WIDTH
);
  logic               load;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] product;

  modport master (output load, output a, output b, input  product);
  modport slave  (input  load, input  a, input  b, output product);
endinterface

// File: rtl/unsigned_seq_mult_rs_step.sv
// One shift-add iteration: conditional add of M into A, then shift {A,Q} right.
module rs_mult_step
  import unsigned_seq_mult_rs_pkg::*;
#(
  parameter int WIDTH = USM_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum;

  // Add keeps the carry in the extra A bit; the shift pulls it back down.
  always_comb begin
    sum = q_i[0] ? (a_i + {1'b0, m_i}) : a_i;
    a_o = {1'b0, sum[WIDTH:1]};
    q_o = {sum[0], q_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/unsigned_seq_mult_rs.sv
// Unsigned right-shift sequential multiplier, one partial product per clock.
//   state   | meaning
//   ST_IDLE | no operation in flight, registers hold
//   ST_BUSY | stepping; product updates on the WIDTH-th step
module unsigned_seq_mult_rs
  import unsigned_seq_mult_rs_pkg::*;
#(
  parameter int WIDTH = USM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  unsigned_seq_mult_rs_if.slave bus
);

  localparam int                CNT_W    = usm_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH:0]     a_q;
  logic [CNT_W-1:0]   cnt_q;
  usm_state_e         state_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH:0]     a_d;
  logic [WIDTH-1:0]   q_d;

  rs_mult_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .q_i (q_q),
    .m_i (m_q),
    .a_o (a_d),
    .q_o (q_d)
  );

  // Load restarts unconditionally; otherwise step while busy and latch the result on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      product_q <= '0;
    end else if (bus.load) begin
      m_q     <= bus.a;
      q_q     <= bus.b;
      a_q     <= '0;
      cnt_q   <= '0;
      state_q <= ST_BUSY;
    end else if (state_q == ST_BUSY) begin
      a_q   <= a_d;
      q_q   <= q_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        product_q <= {a_d[WIDTH-1:0], q_d};
        state_q   <= ST_IDLE;
      end
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_unsigned_seq_mult_rs.sv
// Self-checking bench: directed cases plus random operands against a latency/product model.
module tb_unsigned_seq_mult_rs;

  localparam int W  = 6;
  localparam int PW = 2 * W;

  logic clk;
  logic rst;

  unsigned_seq_mult_rs_if #(.WIDTH(W)) bus ();

  unsigned_seq_mult_rs #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: a result becomes visible W edges after the last load edge,
  // reset forces zero and cancels anything pending.
  logic [PW-1:0] exp_prod;
  logic [PW-1:0] pend_val;
  int            pend_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_prod  <= '0;
      pend_val  <= '0;
      pend_left <= 0;
    end else if (bus.load) begin
      pend_val  <= PW'(int'(bus.a) * int'(bus.b));
      pend_left <= W;
    end else if (pend_left > 0) begin
      pend_left <= pend_left - 1;
      if (pend_left == 1) exp_prod <= pend_val;
    end
  end

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Drive inputs, take one edge, check against the model just after it.
  task automatic cyc(input logic ld, input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.load = ld;
    bus.a    = av;
    bus.b    = bv;
    @(posedge clk);
    #1;
    chk("model", bus.product, exp_prod);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [PW-1:0] want);
    cyc(1'b1, av, bv);
    for (int i = 0; i < W; i++) cyc(1'b0, '0, '0);
    chk("direct", bus.product, want);
  endtask

  logic [W-1:0] ra, rb;
  int           gap;

  initial begin
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    #1;
    chk("reset", bus.product, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_hold", bus.product, '0);

    // Basic, with idle hold afterwards.
    run_op(6'd19, 6'd19, 12'd361);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0);
    chk("hold361", bus.product, 12'd361);

    // Extremes.
    run_op(6'd63, 6'd63, 12'd3969);
    run_op(6'd0,  6'd45, 12'd0);
    run_op(6'd1,  6'd63, 12'd63);
    run_op(6'd63, 6'd1,  12'd63);

    // Reload mid-operation: prior 63 stays until the new result lands.
    cyc(1'b1, 6'd5, 6'd7);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0);
    cyc(1'b1, 6'd10, 6'd12);
    for (int i = 0; i < W - 1; i++) begin
      cyc(1'b0, '0, '0);
      chk("reload_prior", bus.product, 12'd63);
    end
    cyc(1'b0, '0, '0);
    chk("reload_new", bus.product, 12'd120);

    // Held load: latency counts from the last load edge.
    cyc(1'b1, 6'd19, 6'd19);
    cyc(1'b1, 6'd19, 6'd19);
    cyc(1'b1, 6'd19, 6'd19);
    for (int i = 0; i < W - 1; i++) begin
      cyc(1'b0, '0, '0);
      chk("held_prior", bus.product, 12'd120);
    end
    cyc(1'b0, '0, '0);
    chk("held_new", bus.product, 12'd361);

    // Async reset between edges mid-operation.
    cyc(1'b1, 6'd50, 6'd40);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", bus.product, '0);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      cyc(1'b0, '0, '0);
      chk("post_rst", bus.product, '0);
    end

    // Reset together with load captures nothing.
    run_op(6'd7, 6'd9, 12'd63);
    rst = 1'b1;
    cyc(1'b1, 6'd33, 6'd44);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      cyc(1'b0, '0, '0);
      chk("rst_load", bus.product, '0);
    end

    // Random operands.
    for (int n = 0; n < 200; n++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      gap = $urandom_range(6, 9);
      cyc(1'b1, ra, rb);
      for (int i = 0; i < gap; i++) cyc(1'b0, '0, '0);
      chk("rand", bus.product, PW'(int'(ra) * int'(rb)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
